stack_cpu_controller: RTL and testbench

Multi-cycle control unit for the stack-based processor. It consumes the 3-bit opcode from the datapath's instruction register and drives every datapath control strobe, one state per cycle. The design is Moore-style: all strobes decode from the current state, except ALU_OPC in EX, which passes OPC[1:0] through. Sits directly beside the datapath; together they form the CPU top.

---
 rtl/stack_cpu_controller.sv | 197 +++++++++++++++++++
 tb/tb_stack_cpu_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_cpu_controller.sv
// Multi-cycle Moore control unit for the stack CPU: one state per cycle, strobes decoded from state.
// Optional occupancy guard enabled by defining STACK_GUARD_EN (default build: no guard, fault tied 0).
module stack_cpu_controller #(
  parameter int STACK_DEPTH = 8,
  parameter int DEPTH_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] OPC,
  output logic       push,
  output logic       pop,
  output logic       tos,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       Mem_sel,
  output logic       WE,
  output logic       RE,
  output logic       en_IR,
  output logic       en_A,
  output logic       en_B,
  output logic       Stack_sel,
  output logic       ALU_selA,
  output logic       ALU_selB,
  output logic       PC_MUX_sel,
  output logic [1:0] ALU_OPC,
  output logic       instr_done,
  output logic       fault,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_POP1    = 4'd2,
    S_LDA     = 4'd3,
    S_POP2    = 4'd4,
    S_LDB     = 4'd5,
    S_EX      = 4'd6,
    S_WB      = 4'd7,
    S_PUSH_RD = 4'd8,
    S_PUSH_WB = 4'd9,
    S_POP_WR  = 4'd10,
    S_JMP     = 4'd11,
    S_JZ_TOS  = 4'd12,
    S_JZ_BR   = 4'd13,
    S_UNUSED  = 4'd14,
    S_FAULT   = 4'd15
  } state_t;

  if ((2 ** DEPTH_W) <= STACK_DEPTH) begin : g_depth_check
    $error("DEPTH_W too narrow for STACK_DEPTH");
  end

  state_t state_q, state_d;
  logic   guard_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IF;
    else      state_q <= state_d;
  end

`ifdef STACK_GUARD_EN
  logic [DEPTH_W-1:0] occ_q, occ_d;

  // Counter tracks the gated strobes, so an aborted instruction leaves no trace.
  always_comb begin
    occ_d = occ_q + DEPTH_W'(push) - DEPTH_W'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) occ_q <= '0;
    else      occ_q <= occ_d;
  end

  always_comb begin
    guard_ok = 1'b1;
    case (OPC)
      3'b000, 3'b001, 3'b010: guard_ok = (occ_q >= DEPTH_W'(2));
      3'b011, 3'b101, 3'b111: guard_ok = (occ_q >= DEPTH_W'(1));
      3'b100:                 guard_ok = (occ_q < DEPTH_W'(STACK_DEPTH));
      default:                guard_ok = 1'b1;
    endcase
  end

  assign fault = (state_q == S_FAULT);
`else
  assign guard_ok = 1'b1;
  assign fault    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (!guard_ok) begin
          state_d = S_FAULT;
        end else begin
          case (OPC)
            3'b100:  state_d = S_PUSH_RD;
            3'b110:  state_d = S_JMP;
            3'b111:  state_d = S_JZ_TOS;
            default: state_d = S_POP1;
          endcase
        end
      end
      S_POP1, S_JZ_TOS: state_d = S_LDA;
      S_LDA: begin
        case (OPC)
          3'b000, 3'b001, 3'b010: state_d = S_POP2;
          3'b011:                 state_d = S_EX;
          3'b101:                 state_d = S_POP_WR;
          3'b111:                 state_d = S_JZ_BR;
          default:                state_d = S_IF;
        endcase
      end
      S_POP2:    state_d = S_LDB;
      S_LDB:     state_d = S_EX;
      S_EX:      state_d = S_WB;
      S_PUSH_RD: state_d = S_PUSH_WB;
      S_WB, S_PUSH_WB, S_POP_WR, S_JMP, S_JZ_BR: state_d = S_IF;
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_IF;
    endcase
  end

  // Strobes are gated by rst so nothing leaks out while reset is held (state is IF then).
  always_comb begin
    push        = 1'b0;
    pop         = 1'b0;
    tos         = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    Mem_sel     = 1'b0;
    WE          = 1'b0;
    RE          = 1'b0;
    en_IR       = 1'b0;
    en_A        = 1'b0;
    en_B        = 1'b0;
    Stack_sel   = 1'b0;
    ALU_selA    = 1'b0;
    ALU_selB    = 1'b0;
    PC_MUX_sel  = 1'b0;
    ALU_OPC     = 2'b00;
    instr_done  = 1'b0;
    if (rst) begin
      case (state_q)
        S_IF: begin
          RE       = 1'b1;
          en_IR    = 1'b1;
          ALU_selB = 1'b1;
          PCWrite  = 1'b1;
        end
        S_POP1, S_POP2: pop = 1'b1;
        S_JZ_TOS:       tos = 1'b1;
        S_LDA:          en_A = 1'b1;
        S_LDB:          en_B = 1'b1;
        S_EX: begin
          ALU_selA = 1'b1;
          ALU_OPC  = OPC[1:0];
        end
        S_WB: begin
          push       = 1'b1;
          instr_done = 1'b1;
        end
        S_PUSH_RD: begin
          Mem_sel = 1'b1;
          RE      = 1'b1;
        end
        S_PUSH_WB: begin
          Stack_sel  = 1'b1;
          push       = 1'b1;
          instr_done = 1'b1;
        end
        S_POP_WR: begin
          Mem_sel    = 1'b1;
          WE         = 1'b1;
          instr_done = 1'b1;
        end
        S_JMP: begin
          PC_MUX_sel = 1'b1;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
        end
        S_JZ_BR: begin
          PC_MUX_sel  = 1'b1;
          PCWriteCond = 1'b1;
          instr_done  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_stack_cpu_controller.sv
// Bench for stack_cpu_controller: per-cycle expected output vectors queued per instruction and drained against the DUT.
module tb_stack_cpu_controller;

  typedef struct packed {
    logic [3:0] st;
    logic push, pop, tos, pcw, pcwc, mem_sel, we, re, en_ir, en_a, en_b;
    logic stack_sel, sel_a, sel_b, pc_mux;
    logic [1:0] alu;
    logic done, fault;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] OPC = 3'b000;
  logic push, pop, tos, PCWrite, PCWriteCond, Mem_sel, WE, RE;
  logic en_IR, en_A, en_B, Stack_sel, ALU_selA, ALU_selB, PC_MUX_sel;
  logic [1:0] ALU_OPC;
  logic instr_done, fault;
  logic [3:0] state_dbg;

  logic [22:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int occ = 0;

  always #5 clk = ~clk;

  stack_cpu_controller dut (
    .clk(clk), .rst(rst), .OPC(OPC),
    .push(push), .pop(pop), .tos(tos),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .Mem_sel(Mem_sel), .WE(WE), .RE(RE),
    .en_IR(en_IR), .en_A(en_A), .en_B(en_B),
    .Stack_sel(Stack_sel), .ALU_selA(ALU_selA), .ALU_selB(ALU_selB),
    .PC_MUX_sel(PC_MUX_sel), .ALU_OPC(ALU_OPC),
    .instr_done(instr_done), .fault(fault), .state_dbg(state_dbg)
  );

  function automatic obs_t sample();
    obs_t o;
    o.st = state_dbg;     o.push = push;       o.pop = pop;       o.tos = tos;
    o.pcw = PCWrite;      o.pcwc = PCWriteCond; o.mem_sel = Mem_sel; o.we = WE;
    o.re = RE;            o.en_ir = en_IR;     o.en_a = en_A;     o.en_b = en_B;
    o.stack_sel = Stack_sel; o.sel_a = ALU_selA; o.sel_b = ALU_selB;
    o.pc_mux = PC_MUX_sel;   o.alu = ALU_OPC;  o.done = instr_done; o.fault = fault;
    return o;
  endfunction

  // Expected outputs for one state, straight from the per-state strobe table.
  function automatic obs_t exp_obs(int st, logic [2:0] opc);
    obs_t o = '0;
    o.st = 4'(st);
    case (st)
      0:  begin o.re = 1; o.en_ir = 1; o.sel_b = 1; o.pcw = 1; end
      2, 4: o.pop = 1;
      3:  o.en_a = 1;
      5:  o.en_b = 1;
      6:  begin o.sel_a = 1; o.alu = opc[1:0]; end
      7:  begin o.push = 1; o.done = 1; end
      8:  begin o.mem_sel = 1; o.re = 1; end
      9:  begin o.stack_sel = 1; o.push = 1; o.done = 1; end
      10: begin o.mem_sel = 1; o.we = 1; o.done = 1; end
      11: begin o.pc_mux = 1; o.pcw = 1; o.done = 1; end
      12: o.tos = 1;
      13: begin o.pc_mux = 1; o.pcwc = 1; o.done = 1; end
      15: o.fault = 1;
      default: ;
    endcase
    return o;
  endfunction

  // Queue the first n states of an instruction (n<=0 means the whole instruction).
  task automatic queue_instr(logic [2:0] opc, int n);
    int seq[$];
    case (opc)
      3'b000, 3'b001, 3'b010: seq = '{0, 1, 2, 3, 4, 5, 6, 7};
      3'b011: seq = '{0, 1, 2, 3, 6, 7};
      3'b100: seq = '{0, 1, 8, 9};
      3'b101: seq = '{0, 1, 2, 3, 10};
      3'b110: seq = '{0, 1, 11};
      default: seq = '{0, 1, 12, 3, 13};
    endcase
    if (n <= 0) n = seq.size();
    for (int i = 0; i < n; i++) exp_q.push_back(exp_obs(seq[i], opc));
    case (opc)
      3'b000, 3'b001, 3'b010: occ = occ - 1;
      3'b100: occ = occ + 1;
      3'b101: occ = occ - 1;
      default: ;
    endcase
  endtask

  // Scoreboard: one expected vector per clock, sampled 1 time unit after the falling edge.
  task automatic drain(string name);
    obs_t got, exp;
    while (exp_q.size() > 0) begin
      #1;
      got = sample();
      exp = obs_t'(exp_q.pop_front());
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", name, got, got.st, exp, exp.st);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic run_instr(logic [2:0] opc, string name);
    OPC = opc;
    queue_instr(opc, 0);
    drain(name);
  endtask

  task automatic test_reset();
    obs_t got;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    got = sample();
    total++;
    if (got !== obs_t'(0)) begin
      bad++;
      $display("FAIL reset_hold: got %h expected 0", got);
    end
    @(negedge clk);
    rst = 1'b1;
    occ = 0;
  endtask

  task automatic test_push();
    run_instr(3'b100, "push_a");
    run_instr(3'b100, "push_b");
    run_instr(3'b100, "push_c");
  endtask

  task automatic test_alu();
    run_instr(3'b001, "sub");
    run_instr(3'b011, "not");
    run_instr(3'b010, "and");
  endtask

  task automatic test_jumps();
    run_instr(3'b111, "jz");
    run_instr(3'b110, "jmp");
    run_instr(3'b101, "pop");
  endtask

  task automatic test_reset_mid();
    obs_t got;
    run_instr(3'b100, "mid_push_a");
    run_instr(3'b100, "mid_push_b");
    OPC = 3'b001;
    queue_instr(3'b001, 7);
    drain("mid_sub_to_ex");
    #3;
    rst = 1'b0;
    #1;
    got = sample();
    total++;
    if (got !== obs_t'(0)) begin
      bad++;
      $display("FAIL reset_async: got %h expected 0", got);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    got = sample();
    total++;
    if (got !== obs_t'(0)) begin
      bad++;
      $display("FAIL reset_held: got %h expected 0", got);
    end
    @(negedge clk);
    rst = 1'b1;
    occ = 0;
    run_instr(3'b110, "after_reset_jmp");
  endtask

  task automatic test_guard();
    obs_t got;
    test_reset();
    OPC = 3'b000;
`ifdef STACK_GUARD_EN
    exp_q.push_back(exp_obs(0, 3'b000));
    exp_q.push_back(exp_obs(1, 3'b000));
    for (int i = 0; i < 20; i++) exp_q.push_back(exp_obs(15, 3'b000));
    drain("guard_underflow");
    rst = 1'b0;
    #1;
    got = sample();
    total++;
    if (got !== obs_t'(0)) begin
      bad++;
      $display("FAIL guard_clear: got %h expected 0", got);
    end
    @(negedge clk);
    rst = 1'b1;
    occ = 0;
    for (int i = 0; i < 8; i++) run_instr(3'b100, "guard_fill");
    OPC = 3'b100;
    exp_q.push_back(exp_obs(0, 3'b100));
    exp_q.push_back(exp_obs(1, 3'b100));
    for (int i = 0; i < 3; i++) exp_q.push_back(exp_obs(15, 3'b100));
    drain("guard_overflow");
    test_reset();
`else
    run_instr(3'b000, "noguard_add");
    got = sample();
    total++;
    if (got.fault !== 1'b0) begin
      bad++;
      $display("FAIL noguard_fault: got %b expected 0", got.fault);
    end
    test_reset();
`endif
  endtask

  task automatic test_back_to_back();
    logic [2:0] opc;
    for (int i = 0; i < 40; i++) begin
      opc = 3'($urandom_range(0, 7));
      if ((opc <= 3'b010) && (occ < 2)) opc = 3'b100;
      if (((opc == 3'b011) || (opc == 3'b101) || (opc == 3'b111)) && (occ < 1)) opc = 3'b100;
      if ((opc == 3'b100) && (occ >= 8)) opc = 3'b101;
      run_instr(opc, "random");
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_alu();
    test_jumps();
    test_reset_mid();
    test_guard();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
